// File: rtl/disp_pkg.sv
// Shared definitions for the disp_scan7 display stage: segment patterns
// (active-low, {g,f,e,d,c,b,a}) and the conversion FSM state encoding.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } b2b_state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // BCD nibble to segment pattern; non-decimal codes go dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/disp_scan7_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter. One bit is shifted per
// clock; the committed BCD output only changes in the DONE cycle so a reader
// never sees a half-converted value.
//
//   state | meaning
//   IDLE  | waiting for start, committed digits stable
//   SHIFT | add-3 then shift, N cycles, count runs down to 1
//   DONE  | commit accumulator to output, pulse done next cycle
module bin2bcd_seq
    import disp_pkg::*;
#(
    parameter int N      = 8,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          value,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CW = $clog2(N + 1);
    localparam int BW = 4 * DIGITS;
    localparam logic [CW-1:0] CNT_INIT = CW'(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    b2b_state_t         state, state_nxt;
    logic [N-1:0]       shift_q;
    logic [BW-1:0]      acc_q;
    logic [BW-1:0]      acc_adj;
    logic [BW+N-1:0]    shifted;
    logic [CW-1:0]      cnt_q;
    logic [BW-1:0]      bcd_q;
    logic               done_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state and busy decode.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt_q == CNT_LAST) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Add-3 correction on every nibble, then the combined one-bit shift.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
        shifted = {acc_adj, shift_q} << 1;
    end

    // Shift engine, down-counter and committed-digit register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_q <= value;
                        acc_q   <= '0;
                        cnt_q   <= CNT_INIT;
                    end
                end
                SHIFT: begin
                    acc_q   <= shifted[BW+N-1:N];
                    shift_q <= shifted[N-1:0];
                    cnt_q   <= cnt_q - CW'(1);
                end
                DONE: begin
                    bcd_q <= acc_q;
                end
                default: ;
            endcase
        end
    end

    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/disp_scan7.sv
// Display stage: converts the register value to BCD and scans the digits
// onto a common-anode 7-segment display (active-low an and seg).
// Build option: DISP_SCAN7_LZ_BLANK_EN enables leading-zero blanking on
// digits above digit 0.
module disp_scan7
    import disp_pkg::*;
#(
    parameter int N        = 8,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      value,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [DIGITS-1:0] an,
    output logic [7:0]        seg
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    logic [4*DIGITS-1:0] bcd;
    logic [PW-1:0]       presc_q;
    logic [IW-1:0]       idx_q;
    logic [3:0]          nib_sel;
    logic [DIGITS-1:0]   an_nxt;
    logic                blank;
    logic [DIGITS-1:0]   an_q;
    logic [7:0]          seg_q;

    bin2bcd_seq #(
        .N      (N),
        .DIGITS (DIGITS)
    ) u_b2b (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    // Free-running scan prescaler and digit index.
    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else if (presc_q == PRESC_LAST) begin
            presc_q <= '0;
            idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    // Select the nibble and anode pattern for the current index.
    always_comb begin
        nib_sel = 4'd0;
        an_nxt  = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                nib_sel   = bcd[4*i +: 4];
                an_nxt[i] = 1'b0;
            end
        end
    end

`ifdef DISP_SCAN7_LZ_BLANK_EN
    logic [DIGITS-1:0] lead_zero;

    // lead_zero[i]: digit i and every digit above it are zero.
    always_comb begin
        lead_zero = '0;
        lead_zero[DIGITS-1] = (bcd[4*DIGITS-1 -: 4] == 4'd0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            lead_zero[i] = lead_zero[i+1] && (bcd[4*i +: 4] == 4'd0);
        end
        blank = (idx_q != '0) && lead_zero[idx_q];
    end
`else
    assign blank = 1'b0;
`endif

    // Registered pin drivers; dp is never lit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            an_q  <= '1;
            seg_q <= 8'hFF;
        end else begin
            an_q  <= an_nxt;
            seg_q <= {1'b1, blank ? SEG_BLANK : seg_decode(nib_sel)};
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_disp_scan7.sv
// Self-checking bench for disp_scan7 (N=8, DIGITS=4, SCAN_DIV=4).
module tb_disp_scan7;

    logic       clk;
    logic       rst;
    logic [7:0] value;
    logic       start;
    logic       busy;
    logic       done;
    logic [3:0] an;
    logic [7:0] seg;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];
    logic [15:0] cur_digits = 16'h0000;

    disp_scan7 #(
        .N        (8),
        .DIGITS   (4),
        .SCAN_DIV (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .start (start),
        .busy  (busy),
        .done  (done),
        .an    (an),
        .seg   (seg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] exp_seg(input logic [15:0] d, input int idx);
        logic [3:0] nib;
        nib = d[4*idx +: 4];
`ifdef DISP_SCAN7_LZ_BLANK_EN
        if (idx > 0 && (d >> (4 * idx)) == 16'h0) return 8'hFF;
`endif
        case (nib)
            4'd0: return 8'hC0;
            4'd1: return 8'hF9;
            4'd2: return 8'hA4;
            4'd3: return 8'hB0;
            4'd4: return 8'h99;
            4'd5: return 8'h92;
            4'd6: return 8'h82;
            4'd7: return 8'hF8;
            4'd8: return 8'h80;
            4'd9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic int an_to_idx(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic test_reset;
        int idx;
        rst = 1'b0; start = 1'b0; value = 8'd0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0)  begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (an !== 4'hF)    begin bad++; $display("FAIL reset_an: got %b want 1111", an); end
        total++; if (seg !== 8'hFF)  begin bad++; $display("FAIL reset_seg: got %h want ff", seg); end
        rst = 1'b1;
        cur_digits = 16'h0000;
        // First sample is the first cycle after release; index advances every 4 cycles.
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            idx = (j / 4) % 4;
            total++; if (an !== ~(4'b1 << idx)) begin bad++; $display("FAIL scan_order j=%0d: an got %b want %b", j, an, ~(4'b1 << idx)); end
            total++; if (seg !== exp_seg(cur_digits, idx)) begin bad++; $display("FAIL scan_seg_reset j=%0d: got %h want %h", j, seg, exp_seg(cur_digits, idx)); end
        end
    endtask

    // One conversion; at sample chg_k value is changed to chg_v and start
    // optionally re-pulsed while busy (must be ignored).
    task automatic test_convert(input logic [7:0] v, input int chg_k, input logic [7:0] chg_v, input bit chg_start);
        int idx;
        @(negedge clk);
        value = v; start = 1'b1;
        exp_q.push_back(to_bcd(int'(v)));
        @(negedge clk);
        start = 1'b0;
        // Sample k is taken after edge k, edge 0 being the one that took start.
        for (int k = 0; k < 20; k++) begin
            total++; if (busy !== (k <= 8)) begin bad++; $display("FAIL busy v=%0d k=%0d: got %b want %b", v, k, busy, (k <= 8)); end
            total++; if (done !== (k == 9)) begin bad++; $display("FAIL done v=%0d k=%0d: got %b want %b", v, k, done, (k == 9)); end
            if (done === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL sb_underflow v=%0d: got done want none", v); end
                else cur_digits = exp_q.pop_front();
            end
            if (k == chg_k) begin value = chg_v; start = chg_start; end
            if (k == chg_k + 1) start = 1'b0;
            if (k >= 11) begin
                idx = an_to_idx(an);
                total++;
                if (idx < 0) begin bad++; $display("FAIL an_onehot v=%0d: got %b want one low", v, an); end
                else begin
                    total++; if (seg !== exp_seg(cur_digits, idx)) begin bad++; $display("FAIL seg v=%0d idx=%0d: got %h want %h", v, idx, seg, exp_seg(cur_digits, idx)); end
                end
            end
            @(negedge clk);
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_left v=%0d: got %0d pending want 0", v, exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid;
        int idx;
        @(negedge clk);
        value = 8'd200; start = 1'b1;
        exp_q.push_back(to_bcd(200));
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) @(negedge clk);
        rst = 1'b0;   // sampled at edge 4
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rmid_done: got %b want 0", done); end
        total++; if (an !== 4'hF)   begin bad++; $display("FAIL rmid_an: got %b want 1111", an); end
        total++; if (seg !== 8'hFF) begin bad++; $display("FAIL rmid_seg: got %h want ff", seg); end
        rst = 1'b1;
        exp_q.delete();
        cur_digits = 16'h0000;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            idx = (j / 4) % 4;
            total++; if (done !== 1'b0) begin bad++; $display("FAIL rmid_nodone j=%0d: got %b want 0", j, done); end
            total++; if (an !== ~(4'b1 << idx)) begin bad++; $display("FAIL rmid_scan j=%0d: an got %b want %b", j, an, ~(4'b1 << idx)); end
            total++; if (seg !== exp_seg(cur_digits, idx)) begin bad++; $display("FAIL rmid_seg j=%0d: got %h want %h", j, seg, exp_seg(cur_digits, idx)); end
        end
    endtask

    task automatic test_back_to_back;
        int idx;
        int npulse;
        npulse = 0;
        @(negedge clk);
        value = 8'd128; start = 1'b1;
        for (int p = 0; p < 4; p++) exp_q.push_back(to_bcd(128));
        @(negedge clk);
        for (int k = 0; k < 40; k++) begin
            total++; if (busy !== ((k % 10) != 9)) begin bad++; $display("FAIL hold_busy k=%0d: got %b want %b", k, busy, ((k % 10) != 9)); end
            if (done === 1'b1) begin
                total++; if (k != 9 + 10 * npulse) begin bad++; $display("FAIL hold_spacing: got k=%0d want k=%0d", k, 9 + 10 * npulse); end
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL hold_sb_underflow k=%0d: got done want none", k); end
                else cur_digits = exp_q.pop_front();
                npulse++;
            end
            idx = an_to_idx(an);
            total++;
            if (idx < 0) begin bad++; $display("FAIL hold_an k=%0d: got %b want one low", k, an); end
            else begin
                total++; if (seg !== exp_seg(to_bcd(128), idx)) begin bad++; $display("FAIL hold_glitch k=%0d idx=%0d: got %h want %h", k, idx, seg, exp_seg(to_bcd(128), idx)); end
            end
            if (k == 39) start = 1'b0;
            @(negedge clk);
        end
        total++; if (npulse != 4) begin bad++; $display("FAIL hold_pulses: got %0d want 4", npulse); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL hold_idle: got %b want 0", busy); end
        exp_q.delete();
    endtask

    initial begin
        test_reset;
        test_convert(8'd255, -1, 8'd0, 1'b0);
        test_convert(8'd0,   -1, 8'd0, 1'b0);
        test_convert(8'd7,   -1, 8'd0, 1'b0);
        test_convert(8'd100,  2, 8'd42, 1'b1);
        test_convert(8'd12,   1, 8'd99, 1'b0);
        test_reset_mid;
        test_convert(8'd128, -1, 8'd0, 1'b0);
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/disp_scan7.md
Name: disp_scan7

Overview:
- Downstream display stage of the calculator datapath. Consumes the latched register output (q of the operand/result register) and a start strobe.
- Converts the binary value to BCD with a sequential double-dabble engine.
- Time-multiplexes the digits onto a common-anode 7-segment display.
- Sits between the result register and the board's seg/an pins.

Parameters:
- N, 8, width of the binary input value.
- DIGITS, 4, number of display digits / BCD nibbles. Constraint: 10^DIGITS > 2^N-1.
- SCAN_DIV, 16, clock cycles each digit stays lit. Must be ≥2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- value  input  N  binary value to display (register q).
- start  input  1  one-cycle request to convert value.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when new digits are committed.
- an  output  DIGITS  digit enables, active-low, one-hot-zero.
- seg  output  8  {dp,g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset (rst==0 at a clk edge):
  - FSM=IDLE, shift count=0, BCD shadow=0, committed digits=0.
  - Prescaler=0, digit index=0.
  - busy=0, done=0, an=all ones, seg=8'hFF.
- Conversion FSM:
  - IDLE: start==1 → capture value into shift reg, clear BCD accumulator, count=N, go SHIFT. start==0 → stay.
  - SHIFT: each cycle, first add 3 to every BCD nibble ≥5, then shift {bcd,shift} left by one; count−1. After the N-th shift go DONE.
  - DONE: copy accumulator to committed digits, done=1 for this cycle only, go IDLE.
  - busy=1 in SHIFT and DONE, 0 in IDLE.
- Latency: start sampled at edge 0 → committed digits and done valid after edge N+1 (edge 9 for N=8). The new digits appear on seg at the next scan slot of each digit.
- start while busy: ignored, not queued.
- value may change during a conversion; only the captured copy is used.
- Scan:
  - Free-running prescaler 0..SCAN_DIV−1.
  - At the terminal count the prescaler wraps to 0 and the index advances; index DIGITS−1 wraps to 0.
  - an and seg are registered. In the first cycle after reset release they show index 0: an[0]=0, others 1.
  - an[i]=0 exactly when index==i.
  - seg[6:0] = active-low decode of the indexed committed nibble: 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000. Nibbles >9 (unreachable) → 1111111.
  - seg[7] (dp) is always 1.
- The scan runs continuously, independent of the FSM. The committed-digit update is atomic, so a digit never shows a partial BCD value.
- Reset mid-conversion: FSM to IDLE, committed digits cleared, no done pulse.

Optional Feature:
- Macro: DISP_SCAN7_LZ_BLANK_EN.
- Defined: leading-zero blanking. A digit i>0 shows seg=8'hFF when it and every higher digit are 0. Digit 0 is never blanked. an still strobes normally.
- Undefined: all digits show their value, including leading zeros.

Decomposition:
- Shared package disp_pkg:
  - 7-bit segment-pattern constants SEG_0..SEG_9 and SEG_BLANK.
  - FSM state encoding IDLE/SHIFT/DONE, 2-bit.
- Natural sub-module: bin2bcd_seq.
  - Contains the FSM plus shift/add-3 engine.
  - Ports: clk, rst, value, start, busy, done, bcd[4*DIGITS-1:0].
- The top holds the prescaler, index, decode and output registers.

Test Plan:
- Reset, then start with value=8'd255, SCAN_DIV=4 → busy high edges 1..9, done pulse at edge 9, committed digits 0,2,5,5. an cycles 1110,1101,1011,0111, 4 clocks each; seg shows 1000000 (0,MSD), 0010010 (5), 0010010 (5), 0100100 (2) in slots an[3],an[0],an[1],an[2].
- value=8'd0 then value=8'd7 → without the macro, all digits 0 / digits 0,0,0,7. With DISP_SCAN7_LZ_BLANK_EN, only an[0] slot lights: 1000000 / 1111000. All other slots show seg=FF.
- start at edge 0 (value=100), second start at edge 3 (value=42) → exactly one done pulse at edge 9, digits 0,1,0,0. The second request is dropped.
- rst driven low at edge 4 of a conversion → next edge busy=0, an=1111, seg=FF, no done pulse. After release, the scan restarts at an=1110 showing 0.
- value changed to 8'd99 at edge 2 after start with value=8'd12 → result 0,0,1,2.
- Hold start high continuously with value=8'd128 → a new conversion begins every N+2 cycles. done pulses spaced 10 cycles apart; digits steady at 0,1,2,8 with no glitch on seg.
